// File: rtl/q2_pkg.sv
// Shared definitions for the q2 front panel: panel state encoding and the
// default debounce length. Optional macro Q2_PANEL_STEP_EN adds the
// single-step state.
package q2_pkg;

  localparam int unsigned DEBOUNCE_DEFAULT = 16;

`ifdef Q2_PANEL_STEP_EN
  typedef enum logic [1:0] {
    STOPPED  = 2'd0,
    RUNNING  = 2'd1,
    STEPPING = 2'd2
  } panel_state_e;
`else
  typedef enum logic [1:0] {
    STOPPED  = 2'd0,
    RUNNING  = 2'd1
  } panel_state_e;
`endif

endpackage : q2_pkg

// File: rtl/q2_debounce.sv
// One momentary switch: 2-flop synchronizer, stability counter and a
// registered single-cycle pulse on each accepted rising level.
module q2_debounce
  import q2_pkg::*;
#(
  parameter int unsigned DEBOUNCE = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_i,
  output logic pulse_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE + 1);

  logic          sync1_q, sync2_q;
  logic          deb_q, deb_d;
  logic          deb_dly_q;
  logic          pulse_q, pulse_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count cycles of disagreement; flip the accepted level when the count
  // would reach DEBOUNCE, and restart on any agreement.
  always_comb begin
    deb_d   = deb_q;
    cnt_d   = '0;
    pulse_d = deb_q & ~deb_dly_q;
    if (sync2_q != deb_q) begin
      if (cnt_q == CW'(DEBOUNCE - 1)) begin
        deb_d = ~deb_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Synchronizer, counter, accepted level and its delayed copy for edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      cnt_q     <= '0;
      deb_q     <= 1'b0;
      deb_dly_q <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      sync1_q   <= sw_i;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      pulse_q   <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule : q2_debounce

// File: rtl/q2_panel.sv
// Operator front panel: debounces panel switches and drives run/incp/dep to
// the CPU. Defining Q2_PANEL_STEP_EN adds a step switch and STEPPING state.
module q2_panel
  import q2_pkg::*;
#(
  parameter int unsigned WIDTH    = 12,
  parameter int unsigned DEBOUNCE = DEBOUNCE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             incp_sw,
  input  logic             dep_sw,
  input  logic             start_sw,
  input  logic             stop_sw,
  input  logic             halt,
`ifdef Q2_PANEL_STEP_EN
  input  logic             step_sw,
`endif
  output logic             run,
  output logic             incp,
  output logic             dep,
  output logic [WIDTH-1:0] data
);

  logic [WIDTH-1:0] sw_s1_q, sw_s2_q;
  logic             start_p, stop_p, incp_p, dep_p;
`ifdef Q2_PANEL_STEP_EN
  logic             step_p;
`endif

  panel_state_e     state_q, state_d;
  logic             run_q, run_d;
  logic             incp_q, incp_d;
  logic             dep_q, dep_d;
  logic [WIDTH-1:0] data_q, data_d;

  q2_debounce #(.DEBOUNCE(DEBOUNCE)) u_start (.clk(clk), .rst(rst), .sw_i(start_sw), .pulse_o(start_p));
  q2_debounce #(.DEBOUNCE(DEBOUNCE)) u_stop  (.clk(clk), .rst(rst), .sw_i(stop_sw),  .pulse_o(stop_p));
  q2_debounce #(.DEBOUNCE(DEBOUNCE)) u_incp  (.clk(clk), .rst(rst), .sw_i(incp_sw),  .pulse_o(incp_p));
  q2_debounce #(.DEBOUNCE(DEBOUNCE)) u_dep   (.clk(clk), .rst(rst), .sw_i(dep_sw),   .pulse_o(dep_p));
`ifdef Q2_PANEL_STEP_EN
  q2_debounce #(.DEBOUNCE(DEBOUNCE)) u_step  (.clk(clk), .rst(rst), .sw_i(step_sw),  .pulse_o(step_p));
`endif

  // Data switch register synchronizer; sampled only when dep fires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      sw_s1_q <= sw;
      sw_s2_q <= sw_s1_q;
    end
  end

  // Panel state transitions and command generation; pulses outside STOPPED are dropped.
  always_comb begin
    state_d = state_q;
    incp_d  = 1'b0;
    dep_d   = 1'b0;
    data_d  = data_q;
    case (state_q)
      STOPPED: begin
        if (dep_p) begin
          dep_d  = 1'b1;
          data_d = sw_s2_q;
        end else if (incp_p) begin
          incp_d = 1'b1;
        end
        if (start_p && !stop_p && !halt) begin
          state_d = RUNNING;
        end
`ifdef Q2_PANEL_STEP_EN
        else if (step_p && !start_p) begin
          state_d = STEPPING;
        end
`endif
      end
      RUNNING: begin
        if (stop_p || halt) begin
          state_d = STOPPED;
        end
      end
`ifdef Q2_PANEL_STEP_EN
      STEPPING: begin
        state_d = STOPPED;
      end
`endif
      default: begin
        state_d = STOPPED;
      end
    endcase
    run_d = (state_d != STOPPED);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= STOPPED;
      run_q   <= 1'b0;
      incp_q  <= 1'b0;
      dep_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      incp_q  <= incp_d;
      dep_q   <= dep_d;
      data_q  <= data_d;
    end
  end

  assign run  = run_q;
  assign incp = incp_q;
  assign dep  = dep_q;
  assign data = data_q;

endmodule : q2_panel

// File: tb/tb_q2_panel.sv
// Scoreboard bench for q2_panel (DEBOUNCE=4, WIDTH=12): stimulus pushes the
// expected output events with their absolute cycle, a negedge monitor pops
// and compares each event the DUT presents.
module tb_q2_panel;

  localparam int unsigned W = 12;
  localparam int unsigned D = 4;

  typedef enum int {EV_RUN_RISE, EV_RUN_FALL, EV_DEP, EV_INCP} ev_kind_e;
  typedef struct {
    ev_kind_e     kind;
    int           cyc;
    logic [W-1:0] data;
  } ev_t;

  logic         clk;
  logic         rst;
  logic [W-1:0] sw;
  logic         incp_sw, dep_sw, start_sw, stop_sw, halt;
`ifdef Q2_PANEL_STEP_EN
  logic         step_sw;
`endif
  logic         run, incp, dep;
  logic [W-1:0] data;

  ev_t exp_q[$];
  int  cyc    = 0;
  int  t0     = 0;
  int  checks = 0;
  int  errors = 0;
  logic run_prev = 1'b0;

  q2_panel #(.WIDTH(W), .DEBOUNCE(D)) dut (
    .clk(clk), .rst(rst), .sw(sw),
    .incp_sw(incp_sw), .dep_sw(dep_sw), .start_sw(start_sw), .stop_sw(stop_sw),
    .halt(halt),
`ifdef Q2_PANEL_STEP_EN
    .step_sw(step_sw),
`endif
    .run(run), .incp(incp), .dep(dep), .data(data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_exp(input ev_kind_e k, input int ofs, input logic [W-1:0] d);
    ev_t e;
    e.kind = k;
    e.cyc  = t0 + ofs;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_e k);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got %s at cycle %0d data %h, required none", k.name(), cyc, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cyc || ((k == EV_DEP || k == EV_INCP) && e.data != data)) begin
        errors++;
        $display("FAIL event: got %s cycle %0d data %h, required %s cycle %0d data %h",
                 k.name(), cyc, data, e.kind.name(), e.cyc, e.data);
      end
    end
  endtask

  // Monitor: turn run edges and command pulses into events for the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (run && !run_prev) observe(EV_RUN_RISE);
      if (!run && run_prev) observe(EV_RUN_FALL);
      if (dep)              observe(EV_DEP);
      if (incp)             observe(EV_INCP);
    end
    run_prev = run;
  end

  task automatic checkv(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic settle(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected events not seen, first %s at cycle %0d",
               name, exp_q.size(), exp_q[0].kind.name(), exp_q[0].cyc);
      exp_q.delete();
    end
  endtask

  // Drive a switch mask at a negedge; t0 marks the cycle before edge 1.
  task automatic press_on(input logic [4:0] m);
    @(negedge clk);
    start_sw = m[0];
    stop_sw  = m[1];
    incp_sw  = m[2];
    dep_sw   = m[3];
`ifdef Q2_PANEL_STEP_EN
    step_sw  = m[4];
`endif
    t0 = cyc;
  endtask

  task automatic release_all();
    start_sw = 1'b0;
    stop_sw  = 1'b0;
    incp_sw  = 1'b0;
    dep_sw   = 1'b0;
`ifdef Q2_PANEL_STEP_EN
    step_sw  = 1'b0;
`endif
  endtask

  task automatic hold_idle(input int n, input int idle);
    repeat (n) @(negedge clk);
    release_all();
    repeat (idle) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b1;
    sw   = '0;
    halt = 1'b0;
    release_all();
    repeat (3) @(negedge clk);
    checkv("reset_run",  32'(run),  32'd0);
    checkv("reset_incp", 32'(incp), 32'd0);
    checkv("reset_dep",  32'(dep),  32'd0);
    checkv("reset_data", 32'(data), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // dep in STOPPED loads data.
    sw = 12'hA5C;
    press_on(5'b01000); push_exp(EV_DEP, 8, 12'hA5C);
    hold_idle(10, 14); settle("dep_stopped");
    checkv("data_after_dep", 32'(data), 32'hA5C);

    // incp in STOPPED.
    press_on(5'b00100); push_exp(EV_INCP, 8, 12'hA5C);
    hold_idle(10, 14); settle("incp_stopped");

    // dep and incp together: dep only.
    sw = 12'h3C1;
    press_on(5'b01100); push_exp(EV_DEP, 8, 12'h3C1);
    hold_idle(10, 14); settle("dep_incp_same");

    // 2-cycle glitch on start: nothing.
    press_on(5'b00001);
    hold_idle(2, 14); settle("glitch");
    checkv("glitch_run", 32'(run), 32'd0);

    // start held 10 cycles: run from edge 8.
    press_on(5'b00001); push_exp(EV_RUN_RISE, 8, '0);
    hold_idle(10, 14); settle("start");
    checkv("start_run", 32'(run), 32'd1);

    // dep while running: discarded, data holds.
    sw = 12'h7FF;
    press_on(5'b01000);
    hold_idle(10, 14); settle("dep_running");
    checkv("data_held", 32'(data), 32'h3C1);

    // one-cycle halt while running: run low next edge.
    @(negedge clk); halt = 1'b1; t0 = cyc; push_exp(EV_RUN_FALL, 1, '0);
    @(negedge clk); halt = 1'b0;
    repeat (4) @(negedge clk); settle("halt_stop");
    checkv("halt_run", 32'(run), 32'd0);

    // start while halted: discarded.
    @(negedge clk); halt = 1'b1;
    press_on(5'b00001);
    hold_idle(10, 14);
    checkv("halt_blocks_start", 32'(run), 32'd0);
    halt = 1'b0;
    repeat (4) @(negedge clk); settle("halt_blocks_start_ev");

    // start+stop from STOPPED: stays stopped.
    press_on(5'b00011);
    hold_idle(10, 14); settle("start_stop_stopped");
    checkv("start_stop_run", 32'(run), 32'd0);

    // start, then start+stop while running: stop wins.
    press_on(5'b00001); push_exp(EV_RUN_RISE, 8, '0);
    hold_idle(10, 14); settle("start2");
    press_on(5'b00011); push_exp(EV_RUN_FALL, 8, '0);
    hold_idle(10, 14); settle("start_stop_running");
    checkv("stop_wins_run", 32'(run), 32'd0);

`ifdef Q2_PANEL_STEP_EN
    // step: run high for one cycle.
    press_on(5'b10000); push_exp(EV_RUN_RISE, 8, '0); push_exp(EV_RUN_FALL, 9, '0);
    hold_idle(10, 14); settle("step");
    checkv("step_run", 32'(run), 32'd0);
`endif

    // Running, then reset mid-debounce of another start press: all cleared, no pulse.
    press_on(5'b00001); push_exp(EV_RUN_RISE, 8, '0);
    hold_idle(10, 14); settle("start3");
    press_on(5'b00001);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkv("midreset_run",  32'(run),  32'd0);
    checkv("midreset_dep",  32'(dep),  32'd0);
    checkv("midreset_incp", 32'(incp), 32'd0);
    checkv("midreset_data", 32'(data), 32'd0);
    release_all();
    @(negedge clk); rst = 1'b0;
    repeat (14) @(negedge clk); settle("midreset_nopulse");
    checkv("midreset_run_after", 32'(run), 32'd0);

    // Switch held through reset release: new press counted from release.
    @(negedge clk); start_sw = 1'b1; rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; t0 = cyc; push_exp(EV_RUN_RISE, 8, '0);
    hold_idle(10, 14); settle("held_through_reset");
    checkv("held_reset_run", 32'(run), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_q2_panel
